// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator family: FSM states and the result flag bundle.
package cmp_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } cmp_state_e;

    typedef struct packed {
        logic zero;
        logic equal;
        logic less;
        logic greater;
    } cmp_flags_t;

    // Build the result bundle from the final accumulator values.
    function automatic cmp_flags_t flags_from_acc(input logic gt, input logic lt, input logic nz);
        cmp_flags_t f;
        f.zero    = ~nz;
        f.equal   = ~lt & ~gt;
        f.less    = lt;
        f.greater = gt;
        return f;
    endfunction

endpackage

// File: rtl/cmp_serial_step.sv
// One beat of the serial compare: folds a chunk pair into the running gt/lt/nz verdict.
module cmp_serial_step
    import cmp_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             top,
    input  logic             mode,
    input  logic             first,
    input  logic             gt_prev,
    input  logic             lt_prev,
    input  logic             nz_prev,
    output logic             gt_next,
    output logic             lt_next,
    output logic             nz_next
);

    // Flipping the sign bit turns a two's-complement compare into an unsigned one.
    localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

    logic [CHUNK-1:0] xa_s;
    logic [CHUNK-1:0] ya_s;

    // Chunk compare and verdict update; a later unequal chunk overrides earlier ones.
    always_comb begin
        xa_s    = x;
        ya_s    = y;
        gt_next = gt_prev;
        lt_next = lt_prev;
        nz_next = nz_prev;
        if (top && mode) begin
            xa_s = x ^ MSB_MASK;
            ya_s = y ^ MSB_MASK;
        end else begin
            xa_s = x;
            ya_s = y;
        end
        if (first) begin
            gt_next = (xa_s > ya_s);
            lt_next = (xa_s < ya_s);
            nz_next = (|x) | (|y);
        end else begin
            nz_next = nz_prev | (|x) | (|y);
            if (xa_s > ya_s) begin
                gt_next = 1'b1;
                lt_next = 1'b0;
            end else if (xa_s < ya_s) begin
                gt_next = 1'b0;
                lt_next = 1'b1;
            end else begin
                gt_next = gt_prev;
                lt_next = lt_prev;
            end
        end
    end

endmodule

// File: rtl/cmp_serial.sv
// Sequential magnitude comparator: LSB-chunk-first operands, registered flag result.
module cmp_serial
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [CHUNK-1:0] iv_x,
    input  logic [CHUNK-1:0] iv_y,
    input  logic             i_signed,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_zero,
    output logic             o_equal,
    output logic             o_less,
    output logic             o_greater
);

    localparam int BEATS = WIDTH / CHUNK;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    cmp_state_e       state_r;
    cmp_state_e       state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic             gt_r;
    logic             lt_r;
    logic             nz_r;
    logic             mode_r;
    cmp_flags_t       flags_r;

    logic             fire_s;
    logic             first_s;
    logic             last_s;
    logic             mode_eff_s;
    logic             gt_next_s;
    logic             lt_next_s;
    logic             nz_next_s;

    assign o_ready    = (state_r == ACC);
    assign o_valid    = (state_r == HOLD);
    assign fire_s     = i_valid & o_ready;
    assign first_s    = (cnt_r == '0);
    assign last_s     = (cnt_r == LAST_CNT);
    // Beat 0 uses the live mode input so single-beat operation compares in the requested mode.
    assign mode_eff_s = first_s ? i_signed : mode_r;

    assign o_zero     = flags_r.zero;
    assign o_equal    = flags_r.equal;
    assign o_less     = flags_r.less;
    assign o_greater  = flags_r.greater;

    cmp_serial_step #(
        .CHUNK (CHUNK)
    ) u_step (
        .x       (iv_x),
        .y       (iv_y),
        .top     (last_s),
        .mode    (mode_eff_s),
        .first   (first_s),
        .gt_prev (gt_r),
        .lt_prev (lt_r),
        .nz_prev (nz_r),
        .gt_next (gt_next_s),
        .lt_next (lt_next_s),
        .nz_next (nz_next_s)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= ACC;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: the last accepted beat enters HOLD, the result handshake leaves it.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ACC: begin
                if (fire_s && last_s) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = ACC;
                end
            end
            HOLD: begin
                if (i_ready) begin
                    state_next_s = ACC;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: state_next_s = ACC;
        endcase
    end

    // Beat counter, accumulators and the result register; all hold when no beat transfers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_r   <= '0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
            nz_r    <= 1'b0;
            mode_r  <= 1'b0;
            flags_r <= '0;
        end else if (fire_s) begin
            gt_r <= gt_next_s;
            lt_r <= lt_next_s;
            nz_r <= nz_next_s;
            if (first_s) begin
                mode_r <= i_signed;
            end
            if (last_s) begin
                cnt_r   <= '0;
                flags_r <= flags_from_acc(gt_next_s, lt_next_s, nz_next_s);
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cmp_serial.sv
// Self-checking bench for cmp_serial (WIDTH=16, CHUNK=4) against an arithmetic reference model.
module tb_cmp_serial;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int BEATS = WIDTH / CHUNK;

    logic             i_clk = 1'b0;
    logic             i_reset = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [CHUNK-1:0] iv_x = '0;
    logic [CHUNK-1:0] iv_y = '0;
    logic             i_signed = 1'b0;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic             o_zero;
    logic             o_equal;
    logic             o_less;
    logic             o_greater;

    int errors = 0;
    int checks = 0;

    cmp_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .iv_x      (iv_x),
        .iv_y      (iv_y),
        .i_signed  (i_signed),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_zero    (o_zero),
        .o_equal   (o_equal),
        .o_less    (o_less),
        .o_greater (o_greater)
    );

    always #5 i_clk = ~i_clk;

    // Reference: {zero, equal, less, greater} from whole-operand arithmetic.
    function automatic logic [3:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                         input logic s);
        logic lt;
        logic gt;
        if (s) begin
            lt = $signed(x) < $signed(y);
            gt = $signed(x) > $signed(y);
        end else begin
            lt = x < y;
            gt = x > y;
        end
        return {(x == '0) && (y == '0), x == y, lt, gt};
    endfunction

    // Send all beats of one operand pair; s0 drives beat 0, s_rest the later beats.
    task automatic send_operand(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                input logic s0, input logic s_rest, input int max_gap,
                                input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            int gap;
            int w;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                @(negedge i_clk);
                i_valid = 1'b0;
                i_signed = $urandom_range(1, 0) == 1;
            end
            @(negedge i_clk);
            i_valid  = 1'b1;
            iv_x     = x[b*CHUNK +: CHUNK];
            iv_y     = y[b*CHUNK +: CHUNK];
            i_signed = (b == 0) ? s0 : s_rest;
            w = 0;
            while (o_ready !== 1'b1 && w < 20) begin
                @(negedge i_clk);
                w++;
            end
            checks++;
            if (o_ready !== 1'b1) begin
                errors++;
                $display("FAIL beat_ready beat=%0d o_ready=%b required 1", b, o_ready);
            end
            @(posedge i_clk);
            #1;
            i_valid = 1'b0;
        end
    endtask

    // Full operation: beats, latency/flag check, optional backpressure, then consume.
    task automatic run_op(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic s0, input logic s_rest, input int max_gap, input int hold);
        logic [3:0] exp;
        exp = model(x, y, s0);
        send_operand(x, y, s0, s_rest, max_gap, BEATS);
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_latency o_valid=%b o_ready=%b required 1/0", name, o_valid, o_ready);
        end
        checks++;
        if ({o_zero, o_equal, o_less, o_greater} !== exp) begin
            errors++;
            $display("FAIL %s_flags x=%h y=%h s=%b got zelg=%b required %b", name, x, y, s0,
                     {o_zero, o_equal, o_less, o_greater}, exp);
        end
        for (int h = 0; h < hold; h++) begin
            i_ready = 1'b0;
            i_valid = 1'b1;
            @(negedge i_clk);
            checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 ||
                {o_zero, o_equal, o_less, o_greater} !== exp) begin
                errors++;
                $display("FAIL %s_hold cyc=%0d o_valid=%b o_ready=%b zelg=%b required 1/0/%b",
                         name, h, o_valid, o_ready, {o_zero, o_equal, o_less, o_greater}, exp);
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release o_valid=%b o_ready=%b required 0/1", name, o_valid, o_ready);
        end
    endtask

    task automatic apply_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        i_ready = 1'b0;
        i_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 ||
            {o_zero, o_equal, o_less, o_greater} !== 4'b0000) begin
            errors++;
            $display("FAIL %s o_valid=%b o_ready=%b zelg=%b required 0/1/0000", name, o_valid,
                     o_ready, {o_zero, o_equal, o_less, o_greater});
        end
    endtask

    task automatic test_reset();
        apply_reset();
        check_reset_state("reset_state");
    endtask

    task automatic test_basic();
        run_op("lt_1234", 16'h1234, 16'h1235, 1'b0, 1'b0, 0, 0);
        run_op("mode_signed", 16'h8000, 16'h0001, 1'b1, 1'b1, 0, 0);
        run_op("mode_unsigned", 16'h8000, 16'h0001, 1'b0, 1'b0, 0, 0);
        run_op("signed_7fff", 16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 0, 0);
        run_op("zero", 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 0);
        run_op("equal_abcd", 16'hABCD, 16'hABCD, 1'b1, 1'b1, 0, 0);
        run_op("beat2_only", 16'h0F00, 16'h0E00, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_handshake();
        run_op("gaps", 16'h1234, 16'h1235, 1'b0, 1'b0, 3, 0);
        run_op("backpressure", 16'hC001, 16'h4001, 1'b1, 1'b1, 0, 3);
    endtask

    task automatic test_reset_mid();
        send_operand(16'hFFFF, 16'h0000, 1'b0, 1'b0, 0, 2);
        apply_reset();
        check_reset_state("reset_mid_acc");
        run_op("after_reset", 16'h0001, 16'h0002, 1'b0, 1'b0, 0, 0);
        // Reset while holding a result, with a simultaneous result handshake.
        send_operand(16'h9000, 16'h1000, 1'b0, 1'b0, 0, BEATS);
        @(negedge i_clk);
        i_ready = 1'b1;
        apply_reset();
        check_reset_state("reset_in_hold");
        run_op("after_hold_reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_beat0_sampling();
        run_op("beat0_mode", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 0);
        run_op("beat0_mode_u", 16'h0000, 16'hFFFF, 1'b0, 1'b1, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] x;
            logic [WIDTH-1:0] y;
            logic             s;
            x = WIDTH'($urandom);
            y = WIDTH'($urandom);
            // Bias toward shared chunks so the "equal chunk keeps verdict" path is exercised.
            if ($urandom_range(2, 0) == 0) begin
                y = x ^ (WIDTH'($urandom_range(15, 0)) << (4 * $urandom_range(3, 0)));
            end
            s = $urandom_range(1, 0) == 1;
            run_op("random", x, y, s, $urandom_range(1, 0) == 1, 2, $urandom_range(2, 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_handshake();
        test_reset_mid();
        test_beat0_sampling();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
